// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the serial subtractor
package serial_sub_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_sub_ctrl_full_subt.sv
// full_subt: combinational 1-bit full subtractor cell
module full_subt (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ c;
    assign bo = (~a & b) | (~a & c) | (b & c);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial LSB-first subtractor, one bit per cycle through one full_subt cell
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             borrow_q, d_bit, borrow_nx, accept, last;
    assign accept = start && state_q != SHIFT;
    assign last   = cnt_q == CW'(WIDTH - 1);
    assign diff   = diff_q;
    assign bout   = borrow_q;
    full_subt u_cell (.a(a_q[0]), .b(b_q[0]), .c(borrow_q), .d(d_bit), .bo(borrow_nx));
    // next state and status outputs; DONE falls back to IDLE unless restarted
    always_comb begin
        state_d = accept ? SHIFT : state_q == SHIFT ? (last ? DONE : SHIFT) : IDLE;
        busy    = state_q == SHIFT;
        done    = state_q == DONE;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // operand latch on accept, then shift operands right and result in from the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
        end else if (state_q == SHIFT) begin
            a_q      <= a_q >> 1;
            b_q      <= b_q >> 1;
            borrow_q <= borrow_nx;
            diff_q   <= {d_bit, diff_q[WIDTH-1:1]};
            cnt_q    <= cnt_q + CW'(1);
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: scoreboard bench for the serial subtractor at WIDTH 8 and 4
module tb_serial_sub_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       start4 = 1'b0, bin4 = 1'b0, busy4, done4, bout4;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    int tests = 0, fails = 0;
    logic [63:0] q8[$], q4[$];

    serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
    serial_sub_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_sub(input int w, input logic [31:0] a, input logic [31:0] b, input logic bi);
        logic [32:0] d = {1'b0, a} - {1'b0, b} - 33'(bi);
        logic [31:0] m = (32'h1 << w) - 32'h1;
        logic        bo = {1'b0, a} < ({1'b0, b} + 33'(bi));
        return {31'b0, bo, d[31:0] & m};
    endfunction

    function automatic logic [63:0] obs8();
        return {31'b0, bout8, 24'b0, diff8};
    endfunction

    function automatic logic [63:0] obs4();
        return {31'b0, bout4, 28'b0, diff4};
    endfunction

    always @(negedge clk) begin
        if (busy8 || done8) check("busy_done_excl8", busy8 & done8, 0);
        if (busy4 || done4) check("busy_done_excl4", busy4 & done4, 0);
        if (done8) begin
            if (q8.size() == 0) check("spurious_done8", done8, 0);
            else check("result8", obs8(), q8.pop_front());
        end
        if (done4) begin
            if (q4.size() == 0) check("spurious_done4", done4, 0);
            else check("result4", obs4(), q4.pop_front());
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [63:0] e = ref_sub(8, a, b, bi);
        int n = 0;
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        while (busy8 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, 8);
        check("done_pulse", done8, 1);
        @(negedge clk);
        check("done_width", done8, 0);
        check("result_hold", obs8(), e);
    endtask

    initial begin
        int cyc, nd, last_t;
        @(negedge clk);
        check("rst_state8", {busy8, done8, bout8, diff8}, 0);
        check("rst_state4", {busy4, done4, bout4, diff4}, 0);
        rst = 1'b0;
        run8(8'h05, 8'h03, 1'b0);
        run8(8'h03, 8'h05, 1'b0);
        run8(8'h00, 8'h00, 1'b1);
        run8(8'hFF, 8'hFF, 1'b1);
        run8(8'hFF, 8'h00, 1'b0);
        run8(8'hA5, 8'h5A, 1'b1);
        // continuous start: done pulses 9 cycles apart
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        repeat (3) q8.push_back(ref_sub(8, 32'h10, 32'h01, 1'b0));
        nd = 0; cyc = 0; last_t = -1;
        while (nd < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done8) begin
                nd++;
                if (last_t >= 0) check("b2b_gap", cyc - last_t, 9);
                last_t = cyc;
                if (nd == 3) start8 = 1'b0;
            end
        end
        check("b2b_count", nd, 3);
        start8 = 1'b0;
        @(negedge clk);
        // operand change and start pulse during SHIFT are ignored
        a8 = 8'h35; b8 = 8'h17; bin8 = 1'b1; start8 = 1'b1;
        q8.push_back(ref_sub(8, 32'h35, 32'h17, 1'b1));
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_done_seen", done8, 1);
        repeat (12) @(negedge clk);
        check("mid_queue_empty", q8.size(), 0);
        // reset in SHIFT cycle 4 aborts with no done
        a8 = 8'h44; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy8, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {busy8, done8, bout8, diff8}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_no_busy", busy8, 0);
        run8(8'h80, 8'h7F, 1'b0);
        // WIDTH=4 exhaustive sweep, issued back to back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bi); start4 = 1'b1;
                    q4.push_back(ref_sub(4, 32'(a), 32'(b), 1'(bi)));
                    @(negedge clk);
                    start4 = 1'b0;
                    cyc = 0;
                    while (!done4 && cyc < 10) begin
                        @(negedge clk);
                        cyc++;
                    end
                    check("done4_seen", done4, 1);
                end
            end
        end
        repeat (3) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; legal range is 2 to 32.
REQ-002 Port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request to begin one subtraction.
REQ-005 Port a, input, WIDTH bits: minuend, sampled only when start is accepted.
REQ-006 Port b, input, WIDTH bits: subtrahend, sampled only when start is accepted.
REQ-007 Port bin, input, 1 bit: borrow-in, sampled only when start is accepted.
REQ-008 Port busy, output, 1 bit: high while an operation is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 Port diff, output, WIDTH bits: the difference.
REQ-011 Port bout, output, 1 bit: the final borrow-out.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 start SHALL be accepted on a rising edge only when the state is IDLE or DONE.
- On acceptance: latch a, b and bin; clear the bit counter to 0; enter SHIFT.
REQ-014 start SHALL be ignored while in SHIFT, with no effect on the operation in progress.
REQ-015 Each SHIFT edge SHALL process exactly one bit, LSB first, through one 1-bit full-subtractor cell:
- difference bit = a[i] ^ b[i] ^ borrow
- borrow_next = (~a[i] & b[i]) | (~a[i] & borrow) | (b[i] & borrow)
REQ-016 The borrow register SHALL be loaded with bin at acceptance and updated with borrow_next on each SHIFT edge.
REQ-017 The result SHALL be assembled by shifting each difference bit into the MSB of a WIDTH-bit right-shift register.
REQ-018 The bit counter SHALL be $clog2(WIDTH+1) bits wide, incrementing once per SHIFT edge.
REQ-019 On the edge that processes bit WIDTH-1, the FSM SHALL enter DONE.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE unless start is accepted in that cycle.
REQ-021 Timing, where E0 is the accepting edge:
- busy is high in the WIDTH cycles following E0..E(WIDTH-1).
- done is high for exactly the one cycle following E(WIDTH).
REQ-022 While done is high: diff = (a - b - bin) mod 2^WIDTH, and bout = 1 if and only if a < b + bin (unsigned).
REQ-023 diff and bout SHALL hold their values from done until the next accepted start.
REQ-024 diff and bout SHALL NOT be guaranteed valid while busy is high.
REQ-025 busy and done SHALL never be high in the same cycle.
REQ-026 Back-to-back operation: start accepted in DONE SHALL begin the new operation with no idle cycle, so consecutive done pulses are WIDTH+1 cycles apart.
REQ-027 Input changes on a, b or bin during SHIFT SHALL NOT affect the operation in progress.

Reset
REQ-028 While rst is high:
- state = IDLE; counter = 0; borrow = 0
- busy = 0, done = 0, diff = 0, bout = 0
REQ-029 Reset asserted mid-operation SHALL abort it immediately and SHALL produce no done pulse.
REQ-030 After rst deasserts, start SHALL be accepted on the first rising edge.

Structure
REQ-031 Package serial_sub_pkg SHALL hold the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-032 The 1-bit cell SHALL be the existing combinational sub-module full_subt (ports a, b, c, d, bo), instantiated exactly once, with c driven by the borrow register.
REQ-033 All registers SHALL reside in serial_sub_ctrl; full_subt SHALL remain purely combinational.

Verification
REQ-034 WIDTH=8; a=0x05, b=0x03, bin=0; start pulsed once -> busy for 8 cycles, then done for 1 cycle with diff=0x02, bout=0.
REQ-035 WIDTH=8; a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-036 WIDTH=8; start held high continuously with a=0x10, b=0x01 -> done pulses every 9 cycles, each with diff=0x0F, bout=0.
REQ-037 WIDTH=8; at SHIFT cycle 3, change a to 0xFF and pulse start -> result still matches the originally latched operands; exactly one done pulse occurs.
REQ-038 WIDTH=8; assert rst in SHIFT cycle 4 -> all outputs 0 in the same cycle, no done pulse follows; after release, a=0x80, b=0x7F -> diff=0x01, bout=0.
REQ-039 WIDTH=4; exhaustively sweep all a, b, bin -> every diff and bout matches the REQ-022 reference model.
